mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes EX results (rd, wreg, wdata) plus the load/store op, address and store data.
- Performs byte-serial loads and stores on the 8-bit memory bus using a per-byte req/ack handshake.
- Delivers registered writeback fields to the MEM/WB path; holds the pipeline via stall_o while an access is in flight.

---
 rtl/mem_stage.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store stage between EX and WB.
// Moves one byte per req/ack handshake and stalls EX meanwhile.
module mem_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [3:0]            memop_i,
    input  logic [4:0]            rd_i,
    input  logic                  wreg_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    output logic [4:0]            rd_o,
    output logic                  wreg_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  valid_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [7:0]            mem_dout_o,
    input  logic [7:0]            mem_din_i,
    input  logic                  mem_ack_i
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t                state_q;
    state_t                state_d;
    logic [3:0]            op_q;
    logic [4:0]            rd_q;
    logic                  wreg_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] sdata_q;
    logic [1:0]            cnt_q;
    logic [2:0]            nbytes_q;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_d;
    logic                  last_ack;
    logic                  take_mem;

    function automatic logic is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic [2:0] op_size(input logic [3:0] op);
        logic [2:0] n;
        n = 3'd4;
        unique case (1'b1)
            (op == OP_LB) || (op == OP_LBU) || (op == OP_SB): n = 3'd1;
            (op == OP_LH) || (op == OP_LHU) || (op == OP_SH): n = 3'd2;
            default:                                          n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_ext(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a
    );
        logic [DATA_WIDTH-1:0] r;
        r = a;
        unique case (1'b1)
            op == OP_LB:  r = {{(DATA_WIDTH-8){a[7]}}, a[7:0]};
            op == OP_LBU: r = {{(DATA_WIDTH-8){1'b0}}, a[7:0]};
            op == OP_LH:  r = {{(DATA_WIDTH-16){a[15]}}, a[15:0]};
            op == OP_LHU: r = {{(DATA_WIDTH-16){1'b0}}, a[15:0]};
            default:      r = a;
        endcase
        return r;
    endfunction

    // Stall is gated by rst so every output reads 0 while in reset.
    assign take_mem = valid_i && is_mem(memop_i) && rst;

    // Next state, bus drive and byte assembly for the current cycle.
    always_comb begin
        state_d    = state_q;
        stall_o    = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_a_o    = '0;
        mem_dout_o = 8'h00;
        asm_d      = asm_q;
        last_ack   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take_mem) begin
                    stall_o = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                mem_we_o  = is_store(op_q);
                mem_a_o   = addr_q + ADDR_WIDTH'(cnt_q);
                if (is_store(op_q)) begin
                    mem_dout_o = sdata_q[{cnt_q, 3'b000} +: 8];
                end
                if (mem_ack_i) begin
                    if (!is_store(op_q)) begin
                        asm_d[{cnt_q, 3'b000} +: 8] = mem_din_i;
                    end
                    if ({1'b0, cnt_q} == nbytes_q - 3'd1) begin
                        last_ack = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched instruction, byte counter and assembly register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= 4'd0;
            rd_q     <= 5'd0;
            wreg_q   <= 1'b0;
            addr_q   <= '0;
            sdata_q  <= '0;
            cnt_q    <= 2'd0;
            nbytes_q <= 3'd0;
            asm_q    <= '0;
        end else if (state_q == IDLE) begin
            if (take_mem) begin
                op_q     <= memop_i;
                rd_q     <= rd_i;
                wreg_q   <= wreg_i;
                addr_q   <= mem_addr_i;
                sdata_q  <= store_data_i;
                cnt_q    <= 2'd0;
                nbytes_q <= op_size(memop_i);
                asm_q    <= '0;
            end
        end else if (mem_ack_i) begin
            cnt_q <= cnt_q + 2'd1;
            asm_q <= asm_d;
        end
    end

    // Writeback registers toward MEM/WB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_o    <= 5'd0;
            wreg_o  <= 1'b0;
            wdata_o <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (state_q == IDLE) begin
                if (valid_i && !is_mem(memop_i)) begin
                    rd_o    <= rd_i;
                    wreg_o  <= wreg_i;
                    wdata_o <= wdata_i;
                    valid_o <= 1'b1;
                end
            end else if (last_ack) begin
                rd_o    <= rd_q;
                valid_o <= 1'b1;
                if (is_store(op_q)) begin
                    wreg_o  <= 1'b0;
                    wdata_o <= '0;
                end else begin
                    wreg_o  <= wreg_q;
                    wdata_o <= load_ext(op_q, asm_d);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage.
// Byte memory responder with programmable ack delay.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [3:0]  memop_i = 4'd0;
    logic [4:0]  rd_i = 5'd0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] store_data_i = 32'd0;
    logic [4:0]  rd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        valid_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic [7:0]  mem_din_i = 8'h00;
    logic        mem_ack_i = 1'b0;

    mem_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .memop_i      (memop_i),
        .rd_i         (rd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .mem_addr_i   (mem_addr_i),
        .store_data_i (store_data_i),
        .rd_o         (rd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .valid_o      (valid_o),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_a_o      (mem_a_o),
        .mem_dout_o   (mem_dout_o),
        .mem_din_i    (mem_din_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] wdata;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] a;
        logic [7:0]  d;
    } acc_t;

    wb_t  sb_q[$];
    acc_t acc_q[$];
    wb_t  wb_exp;
    acc_t acc_exp;

    logic [7:0] mem [logic [31:0]];

    int n_chk = 0;
    int n_bad = 0;
    int ack_delay = 0;
    int wcnt = 0;
    int ack_cnt = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_a = 32'd0;
    logic [7:0]  prev_d = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory responder: ack after ack_delay wait cycles, check bus hold.
    always @(negedge clk) begin
        mem_ack_i = 1'b0;
        if (mem_req_o === 1'b1) begin
            if (prev_wait) begin
                check("hold_addr", mem_a_o, prev_a);
                check("hold_dout", {24'd0, mem_dout_o}, {24'd0, prev_d});
            end
            if (wcnt >= ack_delay) begin
                mem_ack_i = 1'b1;
                wcnt      = 0;
                prev_wait = 1'b0;
                ack_cnt++;
                if (acc_q.size() == 0) begin
                    check("unexp_access", 32'd1, 32'd0);
                end else begin
                    acc_exp = acc_q.pop_front();
                    check("acc_addr", mem_a_o, acc_exp.a);
                    check("acc_we", {31'd0, mem_we_o}, {31'd0, acc_exp.we});
                    if (acc_exp.we) begin
                        check("wr_byte", {24'd0, mem_dout_o}, {24'd0, acc_exp.d});
                    end
                end
                if (mem_we_o) begin
                    mem[mem_a_o] = mem_dout_o;
                end else begin
                    mem_din_i = mem.exists(mem_a_o) ? mem[mem_a_o] : 8'h00;
                end
            end else begin
                wcnt++;
                prev_wait = 1'b1;
                prev_a    = mem_a_o;
                prev_d    = mem_dout_o;
            end
        end else begin
            wcnt      = 0;
            prev_wait = 1'b0;
        end
    end

    // Writeback monitor: pop scoreboard on every valid_o pulse.
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexp_valid", 32'd1, 32'd0);
            end else begin
                wb_exp = sb_q.pop_front();
                check("rd_o", {27'd0, rd_o}, {27'd0, wb_exp.rd});
                check("wreg_o", {31'd0, wreg_o}, {31'd0, wb_exp.wreg});
                check("wdata_o", wdata_o, wb_exp.wdata);
            end
        end
    end

    task automatic issue(
        input logic [3:0]  op,
        input logic [4:0]  rd,
        input logic        wr,
        input logic [31:0] wd,
        input logic [31:0] addr,
        input logic [31:0] sd,
        input logic [31:0] exp_wd
    );
        wb_t  e;
        acc_t a;
        logic mo;
        logic st;
        int   nb;
        int   n;
        int   cyc;
        mo = (op >= 4'd1) && (op <= 4'd8);
        st = (op >= 4'd6) && (op <= 4'd8);
        nb = (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 :
             (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
        e.rd    = rd;
        e.wreg  = st ? 1'b0 : wr;
        e.wdata = exp_wd;
        sb_q.push_back(e);
        if (mo) begin
            for (int i = 0; i < nb; i++) begin
                a.we = st;
                a.a  = addr + 32'(i);
                a.d  = sd[8*i +: 8];
                acc_q.push_back(a);
            end
        end
        valid_i      = 1'b1;
        memop_i      = op;
        rd_i         = rd;
        wreg_i       = wr;
        wdata_i      = wd;
        mem_addr_i   = addr;
        store_data_i = sd;
        #1;
        check("stall_in", {31'd0, stall_o}, {31'd0, mo});
        if (!mo) begin
            @(negedge clk);
        end else begin
            n = 0;
            for (cyc = 0; cyc < 500; cyc++) begin
                @(negedge clk);
                if (valid_o === 1'b1) break;
                if (mem_req_o === 1'b1) n++;
                check("stall_busy", {31'd0, stall_o}, 32'd1);
            end
            if (cyc >= 500) check("timeout", 32'd0, 32'd1);
            check("req_cycles", n, nb * (ack_delay + 1));
        end
    endtask

    task automatic idle();
        valid_i = 1'b0;
        memop_i = 4'($urandom_range(0, 15));
        #1;
        check("stall_idle", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        check("valid_idle", {31'd0, valid_o}, 32'd0);
        check("req_idle", {31'd0, mem_req_o}, 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd"}, {27'd0, rd_o}, 32'd0);
        check({tag, "_wreg"}, {31'd0, wreg_o}, 32'd0);
        check({tag, "_wdata"}, wdata_o, 32'd0);
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        check({tag, "_req"}, {31'd0, mem_req_o}, 32'd0);
        check({tag, "_we"}, {31'd0, mem_we_o}, 32'd0);
        check({tag, "_a"}, mem_a_o, 32'd0);
        check({tag, "_dout"}, {24'd0, mem_dout_o}, 32'd0);
    endtask

    initial begin
        int base;
        int k;
        mem[32'h100] = 8'h78;
        mem[32'h101] = 8'h56;
        mem[32'h102] = 8'h34;
        mem[32'h103] = 8'h12;
        mem[32'h003] = 8'h80;
        mem[32'h200] = 8'hFF;
        mem[32'h201] = 8'hFF;
        mem[32'h010] = 8'h34;
        mem[32'h011] = 8'h92;

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_i      = 1'($urandom);
            memop_i      = 4'($urandom_range(0, 8));
            rd_i         = 5'($urandom);
            wreg_i       = 1'($urandom);
            wdata_i      = $urandom;
            mem_addr_i   = $urandom;
            store_data_i = $urandom;
            #1;
            check_zero("rst");
        end
        @(negedge clk);
        valid_i = 1'b0;
        rst     = 1'b1;
        idle();
        idle();

        issue(4'd0, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678);
        idle();

        ack_delay = 2;
        issue(4'd3, 5'd6, 1'b1, 32'h0, 32'h100, 32'h0, 32'h1234_5678);
        ack_delay = 0;

        issue(4'd1, 5'd7, 1'b1, 32'h0, 32'h3, 32'h0, 32'hFFFF_FF80);
        issue(4'd4, 5'd8, 1'b1, 32'h0, 32'h3, 32'h0, 32'h0000_0080);
        issue(4'd5, 5'd9, 1'b1, 32'h0, 32'h200, 32'h0, 32'h0000_FFFF);
        issue(4'd2, 5'd10, 1'b1, 32'h0, 32'h10, 32'h0, 32'hFFFF_9234);
        issue(4'd9, 5'd0, 1'b1, 32'hCAFE_BABE, 32'h0, 32'h0, 32'hCAFE_BABE);
        issue(4'd7, 5'd3, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'hAABB_CCDD, 32'h0);
        issue(4'd5, 5'd11, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_CCDD);
        issue(4'd8, 5'd12, 1'b1, 32'h0, 32'h301, 32'hDEAD_BEEF, 32'h0);
        ack_delay = 1;
        issue(4'd3, 5'd13, 1'b0, 32'h0, 32'h301, 32'h0, 32'hDEAD_BEEF);
        ack_delay = 0;
        issue(4'd6, 5'd14, 1'b1, 32'h0, 32'h400, 32'h0000_0055, 32'h0);
        issue(4'd1, 5'd15, 1'b1, 32'h0, 32'h400, 32'h0, 32'h0000_0055);
        idle();

        ack_delay = 1;
        for (int i = 0; i < 4; i++) begin
            acc_exp.we = 1'b0;
            acc_exp.a  = 32'h100 + 32'(i);
            acc_exp.d  = 8'h00;
            acc_q.push_back(acc_exp);
        end
        base         = ack_cnt;
        valid_i      = 1'b1;
        memop_i      = 4'd3;
        rd_i         = 5'd20;
        wreg_i       = 1'b1;
        mem_addr_i   = 32'h100;
        k            = 0;
        while (ack_cnt < base + 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("timeout_rst", 32'd0, 32'd1);
        valid_i = 1'b0;
        @(posedge clk);
        #2;
        check("req_before_rst", {31'd0, mem_req_o}, 32'd1);
        rst = 1'b0;
        #1;
        check("req_async_rst", {31'd0, mem_req_o}, 32'd0);
        check("stall_async_rst", {31'd0, stall_o}, 32'd0);
        check("valid_async_rst", {31'd0, valid_o}, 32'd0);
        acc_q.delete();
        @(negedge clk);
        check_zero("rst_mid");
        rst       = 1'b1;
        ack_delay = 0;
        idle();
        idle();
        issue(4'd0, 5'd9, 1'b1, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0BAD_F00D);
        idle();

        check("sb_left", sb_q.size(), 32'd0);
        check("acc_left", acc_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
